// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC register plus the IF/ID pipeline register.
// Holds the fetch PC, presents it to the instruction memory, and captures the
// fetched word and its PC+4 for decode. Applies load-use stall and
// branch/jump flush, and keeps saturating stall/flush event counters plus a
// sticky flag for the illegal stall-with-flush combination.
module if_id_stage #(
   parameter logic [29:0] RESET_PC = 30'h0000_0C00,
   parameter logic [31:0] NOP_INS  = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [29:0]      NPC,
   input  logic             stall,
   input  logic             if_flush,
   input  logic [31:0]      imem_ins,
   output logic [29:0]      imem_addr,
   output logic [29:0]      PC,
   output logic [29:0]      id_PC_plus_4,
   output logic [31:0]      id_ins,
   output logic             id_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err_conflict
);

   // What the pipeline front end does on the coming edge.
   typedef enum logic [1:0] {
      ACT_RUN   = 2'd0,
      ACT_STALL = 2'd1,
      ACT_FLUSH = 2'd2
   } action_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   action_e     action;
   logic [29:0] pc_q;
   logic [29:0] pc_plus_1;

   assign imem_addr = pc_q;
   assign PC        = pc_q;
   // Word-address increment wraps modulo 2^30 by width truncation.
   assign pc_plus_1 = pc_q + 30'd1;

   // Resolve stall/flush priority: a stall freezes everything, so a flush
   // arriving in the same cycle is dropped rather than applied later.
   always_comb begin
      // NOTE: assign a default first so every path writes action and no latch is inferred.
      action = ACT_RUN;
      if (stall)
         action = ACT_STALL;
      else if (if_flush)
         action = ACT_FLUSH;
   end

   // PC register: hold on stall, otherwise take whatever npc presents.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst)
         pc_q <= RESET_PC;
      else if (action != ACT_STALL)
         pc_q <= NPC;
   end

   // IF/ID register: capture the fetched word, inject a bubble on flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ins       <= NOP_INS;
         id_PC_plus_4 <= 30'd0;
         id_valid     <= 1'b0;
      end else begin
         case (action)
            ACT_FLUSH: begin
               id_ins       <= NOP_INS;
               id_PC_plus_4 <= 30'd0;
               id_valid     <= 1'b0;
            end
            ACT_RUN: begin
               id_ins       <= imem_ins;
               id_PC_plus_4 <= pc_plus_1;
               id_valid     <= 1'b1;
            end
            default: ; // ACT_STALL: hold
         endcase
      end
   end

   // Stalled-cycle counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (action == ACT_STALL && stall_cnt != CNT_MAX)
         stall_cnt <= stall_cnt + 1'b1;
   end

   // Accepted-flush counter, saturating at all-ones; ignored flushes do not count.
   always_ff @(posedge clk) begin
      if (rst)
         flush_cnt <= '0;
      else if (action == ACT_FLUSH && flush_cnt != CNT_MAX)
         flush_cnt <= flush_cnt + 1'b1;
   end

   // Sticky conflict flag: stall and flush together indicate an upstream bug.
   always_ff @(posedge clk) begin
      if (rst)
         err_conflict <= 1'b0;
      else if (stall && if_flush)
         err_conflict <= 1'b1;
   end

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed test of if_id_stage with hand-computed expectations.
// Two instances share all stimulus: one with 16-bit counters, one with 4-bit
// counters for the saturation case.
module tb_if_id_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        if_flush;
   logic        npc_ovr;
   logic [29:0] npc_val;

   logic [29:0] npc_a, npc_b;
   logic [31:0] ins_a, ins_b;
   logic [29:0] addr_a, pc_a, pp4_a, addr_b, pc_b, pp4_b;
   logic [31:0] id_ins_a, id_ins_b;
   logic        valid_a, valid_b, err_a, err_b;
   logic [15:0] scnt_a, fcnt_a;
   logic [3:0]  scnt_b, fcnt_b;

   int checks   = 0;
   int failures = 0;

   // Address-tagged instruction memory: word = {2'b11, addr}, never equal to NOP.
   function automatic logic [31:0] tag(input logic [29:0] a);
      return {2'b11, a};
   endfunction

   assign ins_a = tag(addr_a);
   assign ins_b = tag(addr_b);
   assign npc_a = npc_ovr ? npc_val : pc_a + 30'd1;
   assign npc_b = npc_ovr ? npc_val : pc_b + 30'd1;

   if_id_stage dut (
      .clk(clk), .rst(rst), .NPC(npc_a), .stall(stall), .if_flush(if_flush),
      .imem_ins(ins_a), .imem_addr(addr_a), .PC(pc_a), .id_PC_plus_4(pp4_a),
      .id_ins(id_ins_a), .id_valid(valid_a), .stall_cnt(scnt_a),
      .flush_cnt(fcnt_a), .err_conflict(err_a)
   );

   if_id_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .NPC(npc_b), .stall(stall), .if_flush(if_flush),
      .imem_ins(ins_b), .imem_addr(addr_b), .PC(pc_b), .id_PC_plus_4(pp4_b),
      .id_ins(id_ins_b), .id_valid(valid_b), .stall_cnt(scnt_b),
      .flush_cnt(fcnt_b), .err_conflict(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_if(input string name, input logic [29:0] e_pc,
                           input logic [31:0] e_ins, input logic [29:0] e_pp4,
                           input logic e_valid);
      check({name, ".pc"},    {2'b0, pc_a},   {2'b0, e_pc});
      check({name, ".addr"},  {2'b0, addr_a}, {2'b0, e_pc});
      check({name, ".ins"},   id_ins_a,       e_ins);
      check({name, ".pp4"},   {2'b0, pp4_a},  {2'b0, e_pp4});
      check({name, ".valid"}, {31'b0, valid_a}, {31'b0, e_valid});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; if_flush = 1'b0; npc_ovr = 1'b0; npc_val = '0;

      // Reset state
      step();
      check_if("rst", 30'hC00, 32'h0, 30'h0, 1'b0);
      check("rst.scnt", {16'b0, scnt_a}, 32'd0);
      check("rst.fcnt", {16'b0, fcnt_a}, 32'd0);
      check("rst.err",  {31'b0, err_a},  32'd0);

      // Sequential fetch: id lags PC by one edge
      rst = 1'b0;
      step(); check_if("seq1", 30'hC01, tag(30'hC00), 30'hC01, 1'b1);
      step(); check_if("seq2", 30'hC02, tag(30'hC01), 30'hC02, 1'b1);
      step(); check_if("seq3", 30'hC03, tag(30'hC02), 30'hC03, 1'b1);

      // Two-cycle stall at PC=0xC03
      stall = 1'b1;
      step(); check_if("stl1", 30'hC03, tag(30'hC02), 30'hC03, 1'b1);
      check("stl1.scnt", {16'b0, scnt_a}, 32'd1);
      step(); check_if("stl2", 30'hC03, tag(30'hC02), 30'hC03, 1'b1);
      check("stl2.scnt", {16'b0, scnt_a}, 32'd2);
      stall = 1'b0;
      step(); check_if("res1", 30'hC04, tag(30'hC03), 30'hC04, 1'b1);
      step(); check_if("res2", 30'hC05, tag(30'hC04), 30'hC05, 1'b1);

      // Flush at PC=0xC05 redirecting to 0xC40
      if_flush = 1'b1; npc_ovr = 1'b1; npc_val = 30'hC40;
      step(); check_if("fl", 30'hC40, 32'h0, 30'h0, 1'b0);
      check("fl.fcnt", {16'b0, fcnt_a}, 32'd1);
      check("fl.scnt", {16'b0, scnt_a}, 32'd2);
      if_flush = 1'b0; npc_ovr = 1'b0;
      step(); check_if("tgt", 30'hC41, tag(30'hC40), 30'hC41, 1'b1);

      // Stall and flush together: stall wins, conflict flagged
      stall = 1'b1; if_flush = 1'b1; npc_ovr = 1'b1; npc_val = 30'h100;
      step(); check_if("cf", 30'hC41, tag(30'hC40), 30'hC41, 1'b1);
      check("cf.fcnt", {16'b0, fcnt_a}, 32'd1);
      check("cf.scnt", {16'b0, scnt_a}, 32'd3);
      check("cf.err",  {31'b0, err_a},  32'd1);
      stall = 1'b0; if_flush = 1'b0; npc_ovr = 1'b0;
      step(); check_if("cf2", 30'hC42, tag(30'hC41), 30'hC42, 1'b1);
      check("cf2.err", {31'b0, err_a}, 32'd1);

      // 20 stalled cycles: 4-bit counter saturates, 16-bit keeps counting
      stall = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 11) check("sat.mid4", {28'b0, scnt_b}, 32'd15);
      end
      check("sat.cnt4",  {28'b0, scnt_b}, 32'd15);
      check("sat.cnt16", {16'b0, scnt_a}, 32'd23);
      check("sat.fcnt4", {28'b0, fcnt_b}, 32'd1);
      check("sat.pc4",   {2'b0, pc_b},    32'hC42);
      check("sat.err4",  {31'b0, err_b},  32'd1);
      check_if("sat", 30'hC42, tag(30'hC41), 30'hC42, 1'b1);
      stall = 1'b0;

      // Force PC to the top of the address space; PC+1 wraps to 0
      npc_ovr = 1'b1; npc_val = 30'h3FFF_FFFF;
      step(); check_if("top", 30'h3FFF_FFFF, tag(30'hC42), 30'hC43, 1'b1);
      npc_ovr = 1'b0;
      step(); check_if("wrap", 30'h0, tag(30'h3FFF_FFFF), 30'h0, 1'b1);
      check("wrap.err", {31'b0, err_a}, 32'd1);

      // Reset during stall+flush: reset values win
      rst = 1'b1; stall = 1'b1; if_flush = 1'b1; npc_ovr = 1'b1; npc_val = 30'h55;
      step(); check_if("rst2", 30'hC00, 32'h0, 30'h0, 1'b0);
      check("rst2.scnt", {16'b0, scnt_a}, 32'd0);
      check("rst2.fcnt", {16'b0, fcnt_a}, 32'd0);
      check("rst2.err",  {31'b0, err_a},  32'd0);
      check("rst2.scnt4", {28'b0, scnt_b}, 32'd0);
      rst = 1'b0; stall = 1'b0; if_flush = 1'b0; npc_ovr = 1'b0;
      step(); check_if("post", 30'hC01, tag(30'hC00), 30'hC01, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
